oled_value_writer: RTL and testbench



---
 rtl/oled_value_writer.sv | 233 +++++++++++++++++++++++
 tb/tb_oled_value_writer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_value_writer.sv
// Converts a 12-bit value to four BCD digits and draws them one by one through a
// handshaked OLED character driver. Define OLED_VW_LZB_EN for leading-zero blanking.
module oled_value_writer #(
   parameter logic [4:0] BLANK_CHAR = 5'd10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] iValue,
   input  logic        iValid,
   input  logic        iDrvBusy,
   output logic        oMode,
   output logic [1:0]  oPlaceHolder,
   output logic [4:0]  oChar,
   output logic        oDraw,
   output logic        oBusy,
   output logic        oDone
);
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CONV      = 3'd1,
      WAIT_FREE = 3'd2,
      REQ       = 3'd3,
      RELEASE   = 3'd4,
      NEXT      = 3'd5
   } state_t;

   state_t      stateR, stateS;
   logic [27:0] convR, convS;       // {thousands, hundreds, tens, units, binary}
   logic [3:0]  cntR, cntS;
   logic [1:0]  idxR, idxS;
   logic        pendFlagR, pendFlagS;
   logic [11:0] pendValR, pendValS;
   logic        drawR, drawS;
   logic        busyR, busyS;
   logic        doneR, doneS;
   logic [1:0]  phR, phS;
   logic [4:0]  charR, charS;
   logic        startS;
   logic [11:0] startValS;

   // One double-dabble iteration: +3 on every BCD nibble >= 5, then shift left.
   function automatic logic [27:0] dabbleStep(input logic [27:0] v);
      logic [27:0] a;
      a = v;
      for (int n = 0; n < 4; n++) begin
         if (a[12 + 4*n +: 4] >= 4'd5) begin
            a[12 + 4*n +: 4] = a[12 + 4*n +: 4] + 4'd3;
         end else begin
            a[12 + 4*n +: 4] = a[12 + 4*n +: 4];
         end
      end
      return {a[26:0], 1'b0};
   endfunction

   // Character code for a character position; position 0 is the thousands digit.
   function automatic logic [4:0] charFor(input logic [15:0] bcd, input logic [1:0] idx);
      logic [3:0] d;
      logic [4:0] c;
`ifdef OLED_VW_LZB_EN
      logic       lead;
`endif
      case (idx)
         2'd0:    d = bcd[15:12];
         2'd1:    d = bcd[11:8];
         2'd2:    d = bcd[7:4];
         default: d = bcd[3:0];
      endcase
`ifdef OLED_VW_LZB_EN
      // Units are never blanked so a zero value still shows "0".
      case (idx)
         2'd0:    lead = (bcd[15:12] == 4'd0);
         2'd1:    lead = (bcd[15:8] == 8'd0);
         2'd2:    lead = (bcd[15:4] == 12'd0);
         default: lead = 1'b0;
      endcase
      if (lead) begin
         c = BLANK_CHAR;
      end else begin
         c = {1'b0, d};
      end
`else
      c = {1'b0, d};
`endif
      return c;
   endfunction

   // Next-state and next-output logic.
   always_comb begin
      stateS    = stateR;
      convS     = convR;
      cntS      = cntR;
      idxS      = idxR;
      pendFlagS = pendFlagR;
      pendValS  = pendValR;
      drawS     = drawR;
      busyS     = busyR;
      doneS     = 1'b0;
      phS       = phR;
      charS     = charR;
      startS    = 1'b0;
      startValS = iValue;

      if (iValid && (stateR != IDLE)) begin
         pendFlagS = 1'b1;
         pendValS  = iValue;
      end else begin
         pendFlagS = pendFlagR;
      end

      case (stateR)
         IDLE: begin
            drawS = 1'b0;
            if (iValid) begin
               startS    = 1'b1;
               startValS = iValue;
            end else if (pendFlagR) begin
               startS    = 1'b1;
               startValS = pendValR;
            end else begin
               busyS = 1'b0;
            end
         end
         CONV: begin
            convS = dabbleStep(convR);
            cntS  = cntR + 4'd1;
            if (cntR == 4'd11) begin
               stateS = WAIT_FREE;
            end else begin
               stateS = CONV;
            end
         end
         WAIT_FREE: begin
            drawS = 1'b0;
            if (!iDrvBusy) begin
               stateS = REQ;
               phS    = idxR;
               charS  = charFor(convR[27:12], idxR);
            end else begin
               stateS = WAIT_FREE;
            end
         end
         REQ: begin
            // Busy only counts as an acknowledge once our request is visible.
            if (drawR && iDrvBusy) begin
               drawS  = 1'b0;
               stateS = RELEASE;
            end else begin
               drawS  = 1'b1;
               stateS = REQ;
            end
         end
         RELEASE: begin
            drawS = 1'b0;
            if (!iDrvBusy) begin
               stateS = NEXT;
            end else begin
               stateS = RELEASE;
            end
         end
         NEXT: begin
            drawS = 1'b0;
            if (idxR != 2'd3) begin
               idxS   = idxR + 2'd1;
               stateS = WAIT_FREE;
            end else begin
               doneS = 1'b1;
               if (iValid) begin
                  startS    = 1'b1;
                  startValS = iValue;
               end else if (pendFlagR) begin
                  startS    = 1'b1;
                  startValS = pendValR;
               end else begin
                  busyS  = 1'b0;
                  stateS = IDLE;
               end
            end
         end
         default: begin
            stateS = IDLE;
            drawS  = 1'b0;
            busyS  = 1'b0;
         end
      endcase

      if (startS) begin
         convS     = {16'd0, startValS};
         cntS      = 4'd0;
         idxS      = 2'd0;
         busyS     = 1'b1;
         pendFlagS = 1'b0;
         stateS    = CONV;
      end else begin
         stateS = stateS;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateR    <= IDLE;
         convR     <= 28'd0;
         cntR      <= 4'd0;
         idxR      <= 2'd0;
         pendFlagR <= 1'b0;
         pendValR  <= 12'd0;
         drawR     <= 1'b0;
         busyR     <= 1'b0;
         doneR     <= 1'b0;
         phR       <= 2'd0;
         charR     <= 5'd0;
      end else begin
         stateR    <= stateS;
         convR     <= convS;
         cntR      <= cntS;
         idxR      <= idxS;
         pendFlagR <= pendFlagS;
         pendValR  <= pendValS;
         drawR     <= drawS;
         busyR     <= busyS;
         doneR     <= doneS;
         phR       <= phS;
         charR     <= charS;
      end
   end

   assign oMode        = 1'b0;
   assign oPlaceHolder = phR;
   assign oChar        = charR;
   assign oDraw        = drawR;
   assign oBusy        = busyR;
   assign oDone        = doneR;
endmodule

// File: tb/tb_oled_value_writer.sv
// Directed bench for oled_value_writer: table-driven digit checks plus hand-written
// sequences for latency, pending values, driver hold-off and mid-draw reset.
`timescale 1ns/1ps
module tb_oled_value_writer;
   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] value;
   logic        valid;
   logic        forceBusy;
   logic        modelBusy;
   logic        drvBusy;
   logic        oMode;
   logic [1:0]  oPlaceHolder;
   logic [4:0]  oChar;
   logic        oDraw;
   logic        oBusy;
   logic        oDone;

`ifdef OLED_VW_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   oled_value_writer dut (
      .clk(clk), .rst(rst), .iValue(value), .iValid(valid), .iDrvBusy(drvBusy),
      .oMode(oMode), .oPlaceHolder(oPlaceHolder), .oChar(oChar),
      .oDraw(oDraw), .oBusy(oBusy), .oDone(oDone)
   );

   always #5 clk = ~clk;
   assign drvBusy = forceBusy | modelBusy;

   int checks = 0;
   int failures = 0;
   int phLog[$];
   int chLog[$];
   int releases = 0;
   int stabErr = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Driver model: latches each new draw request, then stays busy 20 cycles.
   initial begin
      int cnt;
      logic prevDraw;
      modelBusy = 1'b0;
      cnt = 0;
      prevDraw = 1'b0;
      forever begin
         @(negedge clk);
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               modelBusy = 1'b0;
               releases++;
            end
         end else if (oDraw && !prevDraw && !drvBusy) begin
            phLog.push_back(int'(oPlaceHolder));
            chLog.push_back(int'(oChar));
            modelBusy = 1'b1;
            cnt = 20;
         end
         prevDraw = oDraw;
      end
   end

   // Character position and code must not move while a request is up.
   initial begin
      logic [1:0] p;
      logic [4:0] c;
      logic d;
      p = 2'd0; c = 5'd0; d = 1'b0;
      forever begin
         @(negedge clk);
         if (d && oDraw && ((oPlaceHolder != p) || (oChar != c))) stabErr++;
         p = oPlaceHolder; c = oChar; d = oDraw;
      end
   end

   task automatic pulseValid(input logic [11:0] v);
      @(negedge clk);
      value = v;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic waitDones(input string name, input int n, output int busyDrops);
      int seen;
      seen = 0;
      busyDrops = 0;
      for (int k = 0; k < 4000 && seen < n; k++) begin
         @(negedge clk);
         if (oDone) seen++;
         if (!oBusy && seen < n) busyDrops++;
      end
      check($sformatf("%s_dones", name), seen, n);
   endtask

   task automatic checkLog(input string name, input int n, input int e[8]);
      check($sformatf("%s_count", name), phLog.size(), n);
      for (int j = 0; j < n; j++) begin
         check($sformatf("%s_ph%0d", name, j), (j < phLog.size()) ? phLog[j] : -1, j % 4);
         check($sformatf("%s_ch%0d", name, j), (j < chLog.size()) ? chLog[j] : -1, e[j]);
      end
   endtask

   typedef struct {
      logic [11:0] v;
      int e0, e1, e2, e3;
   } vec_t;

   initial begin
      vec_t vecs[7];
      int   expArr[8];
      int   B;
      int   drops;
      int   extra;
      int   sawDraw;
      int   found;
      int   rel0;

      B = LZB ? 10 : 0;
      vecs[0] = '{12'd1234, 1, 2, 3, 4};
      vecs[1] = '{12'd7,    B, B, B, 7};
      vecs[2] = '{12'd4095, 4, 0, 9, 5};
      vecs[3] = '{12'd0,    B, B, B, 0};
      vecs[4] = '{12'd305,  B, 3, 0, 5};
      vecs[5] = '{12'd1000, 1, 0, 0, 0};
      vecs[6] = '{12'd40,   B, B, 4, 0};

      rst = 1'b1; valid = 1'b0; value = 12'd0; forceBusy = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_draw", int'(oDraw), 0);
      check("rst_busy", int'(oBusy), 0);
      check("rst_done", int'(oDone), 0);
      check("rst_mode", int'(oMode), 0);
      check("rst_ph", int'(oPlaceHolder), 0);
      check("rst_char", int'(oChar), 0);
      rst = 1'b0;

      // First request lands on the 14th edge after the sampling edge.
      pulseValid(12'd1234);
      check("lat_busy", int'(oBusy), 1);
      repeat (13) @(negedge clk);
      check("lat_edge13", int'(oDraw), 0);
      @(negedge clk);
      check("lat_edge14", int'(oDraw), 1);
      waitDones("lat", 1, drops);

      for (int i = 0; i < 7; i++) begin
         repeat (2) @(negedge clk);
         phLog.delete(); chLog.delete();
         pulseValid(vecs[i].v);
         waitDones($sformatf("vec%0d", i), 1, drops);
         extra = 0;
         repeat (3) begin
            @(negedge clk);
            if (oDone) extra++;
         end
         check($sformatf("vec%0d_single_done", i), extra, 0);
         check($sformatf("vec%0d_idle_busy", i), int'(oBusy), 0);
         expArr = '{vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3, 0, 0, 0, 0};
         checkLog($sformatf("vec%0d", i), 4, expArr);
      end

      // Values arriving mid-update: newest pending wins, oBusy never drops.
      repeat (2) @(negedge clk);
      phLog.delete(); chLog.delete();
      pulseValid(12'd4000);
      found = 0;
      for (int k = 0; k < 200 && found == 0; k++) begin
         @(negedge clk);
         if (oDraw) found = 1;
      end
      check("pend_first_draw", found, 1);
      pulseValid(12'd100);
      repeat (2) @(negedge clk);
      pulseValid(12'd200);
      waitDones("pend", 2, drops);
      check("pend_busy_gap", drops, 0);
      repeat (40) @(negedge clk);
      expArr = '{4, 0, 0, 0, B, 2, 0, 0};
      checkLog("pend", 8, expArr);

      // iValid in the very cycle of the final NEXT.
      phLog.delete(); chLog.delete();
      rel0 = releases;
      pulseValid(12'd1234);
      found = 0;
      for (int k = 0; k < 3000 && found == 0; k++) begin
         @(negedge clk);
         #1;
         if (releases == rel0 + 4) found = 1;
      end
      check("nx_fourth_release", found, 1);
      @(negedge clk);
      value = 12'd56;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      check("nx_done", int'(oDone), 1);
      check("nx_busy", int'(oBusy), 1);
      waitDones("nx", 1, drops);
      repeat (40) @(negedge clk);
      expArr = '{1, 2, 3, 4, B, B, 5, 6};
      checkLog("nx", 8, expArr);

      // Driver held busy: no request until it frees up.
      phLog.delete(); chLog.delete();
      forceBusy = 1'b1;
      pulseValid(12'd321);
      sawDraw = 0;
      repeat (1000) begin
         @(negedge clk);
         if (oDraw) sawDraw++;
      end
      check("hold_nodraw", sawDraw, 0);
      check("hold_busy", int'(oBusy), 1);
      forceBusy = 1'b0;
      waitDones("hold", 1, drops);
      expArr = '{B, 3, 2, 1, 0, 0, 0, 0};
      checkLog("hold", 4, expArr);

      // Reset while character position 2 is being requested.
      repeat (2) @(negedge clk);
      pulseValid(12'd1234);
      found = 0;
      for (int k = 0; k < 3000 && found == 0; k++) begin
         @(negedge clk);
         if (oDraw && oPlaceHolder == 2'd2) found = 1;
      end
      check("mrst_found", found, 1);
      #2 rst = 1'b1;
      #1;
      check("mrst_draw", int'(oDraw), 0);
      check("mrst_busy", int'(oBusy), 0);
      check("mrst_done", int'(oDone), 0);
      check("mrst_ph", int'(oPlaceHolder), 0);
      check("mrst_char", int'(oChar), 0);
      @(negedge clk);
      rst = 1'b0;
      sawDraw = 0;
      repeat (200) begin
         @(negedge clk);
         if (oDraw) sawDraw++;
      end
      check("mrst_nodraw", sawDraw, 0);
      check("mrst_idle_busy", int'(oBusy), 0);
      phLog.delete(); chLog.delete();
      pulseValid(12'd88);
      waitDones("post", 1, drops);
      expArr = '{B, B, 8, 8, 0, 0, 0, 0};
      checkLog("post", 4, expArr);

      check("stable_ph_char", stabErr, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
